pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central pipeline control block for the 5-stage core. Detects load-use hazards, taken-branch flushes and multi-cycle (MDU) operations in EX. Drives the write-enable and synchronous-flush inputs of the PC and the IF/ID, ID/EX and EX/MEM stage registers. Each stage register's reset input is the OR of global `reset` and its flush output from this block, so flush overrides write enable.

## Interface
- MUL_CYCLES, 4, total cycles an MDU op occupies EX; legal range 2..16
- CNT_W, 32, width of the stall performance counter
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_rs  in  5  source register 1 of the instruction in ID
- id_rt  in  5  source register 2 of the instruction in ID
- id_uses_rt  in  1  ID instruction actually reads rt
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- ex_mdu_op  in  1  EX holds a multi-cycle multiply/divide
- pc_we  out  1  PC write enable
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID synchronous clear
- id_ex_we  out  1  ID/EX write enable
- id_ex_flush  out  1  ID/EX synchronous clear (bubble)
- ex_mem_flush  out  1  EX/MEM synchronous clear (bubble)
- mdu_busy  out  1  MDU stall in progress
- mdu_done  out  1  one-cycle pulse on MDU release cycle
- stall_cycles  out  CNT_W  saturating count of stalled cycles

## Operation
- States: RUN and BUSY. A CNT-bit down-counter `cnt` tracks BUSY, with CNT = ceil(log2(MUL_CYCLES)).
- Default in RUN with no event: all `*_we` = 1, all flushes = 0, mdu_busy = 0, mdu_done = 0.
- Priority, highest first: reset > MDU stall > branch flush > load-use stall.
- MDU stall is asserted in RUN when ex_mdu_op = 1, and in BUSY while cnt != 0.
  - Outputs: pc_we = if_id_we = id_ex_we = 0, ex_mem_flush = 1, mdu_busy = 1, other flushes = 0.
  - RUN with ex_mdu_op: next state BUSY, cnt <= MUL_CYCLES-2.
  - BUSY with cnt != 0: cnt <= cnt-1.
  - BUSY with cnt == 0 (release cycle): no stall, mdu_done = 1, mdu_busy = 0, all we = 1, next state RUN.
  - ex_mdu_op is ignored in BUSY, so the held op never retriggers.
- Branch flush, when ex_branch_taken = 1 and there is no MDU stall:
  - pc_we = 1, so the target loads.
  - if_id_flush = 1 and id_ex_flush = 1.
  - if_id_we = id_ex_we = 1.
  - Any simultaneous load-use condition is ignored, because the younger instructions are being killed.
- Load-use stall, when ex_mem_read and ex_rd != 0 and (ex_rd == id_rs or (id_uses_rt and ex_rd == id_rt)):
  - pc_we = 0, if_id_we = 0, id_ex_flush = 1, id_ex_we = 1.
  - This inserts one bubble. Decode guarantees the next cycle has no load in EX, so it never exceeds one cycle.
- ex_branch_taken and ex_mdu_op are mutually exclusive by decode. If both are asserted, MDU wins and the branch is dropped.
- stall_cycles increments by 1 each non-reset cycle with pc_we = 0. It saturates at all-ones and does not wrap.

## Timing
- All outputs except stall_cycles are combinational from (state, cnt, inputs) and are valid in the same cycle.
- state, cnt and stall_cycles update on posedge clk.
- Reset behaviour:
  - state <= RUN, cnt <= 0, stall_cycles <= 0.
  - While reset = 1, outputs are forced: all `*_we` = 0, all flushes = 1, mdu_busy = 0, mdu_done = 0.
  - Reset during BUSY aborts the op. The first cycle after reset deasserts is RUN.
- MDU op entering EX at cycle t:
  - Stalled cycles are t .. t+MUL_CYCLES-2, i.e. MUL_CYCLES-1 cycles.
  - The release cycle, with mdu_done = 1, is t+MUL_CYCLES-1.
  - The next instruction is in EX at t+MUL_CYCLES.
- MUL_CYCLES = 2: BUSY is entered with cnt = 0, giving one stall cycle followed immediately by release.
- Load-use stall lasts exactly one cycle. The dependent instruction stays in ID and resolves via forwarding next cycle.

## Test plan
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs = 5 for one cycle -> that cycle pc_we = 0, if_id_we = 0, id_ex_flush = 1; stall_cycles = 1 after the edge. Repeat with ex_rd = 0 -> no stall.
- id_uses_rt gating: ex_rd = 7 = id_rt, id_uses_rt = 0 -> no stall. Same with id_uses_rt = 1 -> stall.
- MDU with MUL_CYCLES = 4: ex_mdu_op held high from cycle t until mdu_done -> mdu_busy = 1 at t, t+1, t+2; mdu_done = 1 only at t+3; stall_cycles = 3.
- Branch plus load-use in the same cycle: ex_branch_taken = 1 and load-use match -> pc_we = 1, if_id_flush = 1, id_ex_flush = 1, no stall counted.
- Reset mid-BUSY: assert reset at t+1 of an MDU op -> outputs forced (we = 0, flushes = 1); after release state is RUN, mdu_busy = 0, stall_cycles = 0.
- Saturation with CNT_W = 4: hold a load-use condition for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: decode/EX hazard sources in, stage-register controls out.
// The controller is the slave; the pipeline datapath (or a bench) is the master.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             ex_mdu_op;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_we;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mdu_busy;
  logic             mdu_done;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, ex_branch_taken, ex_mdu_op,
    input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush,
           mdu_busy, mdu_done, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read, ex_branch_taken, ex_mdu_op,
    output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush,
           mdu_busy, mdu_done, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: MDU stall, taken-branch flush and load-use bubble
// for the 5-stage core, plus a saturating stalled-cycle counter.
//
// state | meaning
// RUN   | normal issue; branch/load-use hazards resolved here, MDU op starts stall
// BUSY  | MDU op held in EX; cnt counts remaining stall cycles, release at cnt == 0
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input logic                    clk,
  input logic                    reset,
  pipeline_hazard_ctrl_if.slave  hz
);
  localparam int CNT_BITS = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MUL_CYCLES - 2);

  typedef enum logic {RUN, BUSY} state_t;

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0]    stall_cnt;
  logic                load_use;
  logic                pc_we_c;
  logic                if_id_we_c, if_id_flush_c, id_ex_we_c, id_ex_flush_c;
  logic                ex_mem_flush_c, mdu_busy_c, mdu_done_c;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_we_c && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pc_we_c        = 1'b1;
    if_id_we_c     = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_we_c     = 1'b1;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    mdu_busy_c     = 1'b0;
    mdu_done_c     = 1'b0;

    if (reset) begin
      pc_we_c        = 1'b0;
      if_id_we_c     = 1'b0;
      id_ex_we_c     = 1'b0;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
      ex_mem_flush_c = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (hz.ex_mdu_op) begin
            pc_we_c        = 1'b0;
            if_id_we_c     = 1'b0;
            id_ex_we_c     = 1'b0;
            ex_mem_flush_c = 1'b1;
            mdu_busy_c     = 1'b1;
            state_nxt      = BUSY;
            cnt_nxt        = CNT_LOAD;
          end else if (hz.ex_branch_taken) begin
            // younger instructions are killed, so a coincident load-use is moot
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (load_use) begin
            pc_we_c       = 1'b0;
            if_id_we_c    = 1'b0;
            id_ex_flush_c = 1'b1;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            pc_we_c        = 1'b0;
            if_id_we_c     = 1'b0;
            id_ex_we_c     = 1'b0;
            ex_mem_flush_c = 1'b1;
            mdu_busy_c     = 1'b1;
            cnt_nxt        = cnt - 1'b1;
          end else begin
            mdu_done_c = 1'b1;
            state_nxt  = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign hz.pc_we        = pc_we_c;
  assign hz.if_id_we     = if_id_we_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.id_ex_we     = id_ex_we_c;
  assign hz.id_ex_flush  = id_ex_flush_c;
  assign hz.ex_mem_flush = ex_mem_flush_c;
  assign hz.mdu_busy     = mdu_busy_c;
  assign hz.mdu_done     = mdu_done_c;
  assign hz.stall_cycles = stall_cnt;
endmodule
